fp_add_sub: RTL and testbench
=============================

Name: fp_add_sub

Overview:
- Pipelined IEEE-754 single-precision floating-point adder/subtractor.
- Used by the effects-processor arithmetic layer behind a start/done wrapper.
- The wrapper holds clk_en for exactly 7 cycles, then reads result.
- Fixed latency of 7 clock-enabled cycles; a new operation may be issued every enabled cycle.

Parameters:
- LATENCY, 7, number of clk_en-qualified pipeline stages from input sample to result. Fixed; the wrapper depends on 7.

Ports:
- clock    input   1   rising-edge clock
- reset_n  input   1   asynchronous active-low reset
- clk_en   input   1   pipeline advance enable; low freezes every stage
- add_sub  input   1   1 = dataa + datab, 0 = dataa - datab
- dataa    input   32  operand A, IEEE-754 binary32
- datab    input   32  operand B, IEEE-754 binary32
- result   output  32  registered binary32 result

Behaviour:
- Reset: reset_n low asynchronously clears all pipeline registers. result = 0x00000000 while reset_n is low and until the first operation emerges.
- Pipeline: dataa, datab and add_sub are sampled on a rising edge with clk_en=1. The result appears on result after the 7th such edge, counting the sampling edge as edge 1.
- Stall: with clk_en=0, all stages hold, including result. Stall cycles do not count toward latency.
- Throughput: one operation per enabled cycle. Back-to-back results emerge in issue order.
- Subtraction: invert the sign of datab, then add.
- Suggested stage split, internal only:
  - unpack and special-case detect
  - exponent compare and swap
  - align shift with sticky bit
  - significand add/sub, 24+3 guard/round/sticky bits
  - leading-zero count and normalize
  - round
  - pack
- Rounding: round-to-nearest, ties-to-even.
- Denormal inputs (exp=0, frac≠0) are treated as zero of the same sign.
- Results below the minimum normal flush to signed zero.
- Overflow after rounding gives ±infinity (0x7F800000 / 0xFF800000).
- Any NaN input gives canonical quiet NaN 0x7FC00000.
- inf − inf (effective subtraction of equal infinities) gives 0x7FC00000.
- inf ± finite gives that infinity with its sign.
- Exact cancellation (x − x) gives +0 (0x00000000).
- (−0) + (−0) gives −0 (0x80000000). Any other zero-sum gives +0.
- Alignment shift ≥ 26 collapses the smaller operand into the sticky bit only.
- No exception flag outputs.
- reset_n asserted mid-operation discards all in-flight operations. result returns to 0 immediately.

Test Plan:
- 1.0 + 2.0: dataa=0x3F800000, datab=0x40000000, add_sub=1, clk_en held high → result=0x40400000 after exactly 7 edges. After 6 edges result still shows the old value.
- Subtraction: 0x3FC00000 − 0x3F000000, add_sub=0 → 0x3F800000.
- Cancellation: 0x3F800000 − 0x3F800000 → 0x00000000.
- Rounding, tie to even: 0x3F800000 + 0x33800000 → 0x3F800000.
- Rounding, above half: 0x3F800000 + 0x33C00000 → 0x3F800001.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000
  - 0x7F800000 + 0xFF800000 → 0x7FC00000
  - 0x00000001 + 0x00000000 → 0x00000000
- Stall and pipelining:
  - Issue 1.0+2.0, then 1.5−0.5 on consecutive cycles.
  - Drop clk_en for 3 cycles mid-flight.
  - Results appear in order, each after 7 enabled edges. result is frozen during the stall.
  - Assert reset_n low mid-flight → result immediately 0x00000000, and no stale results emerge afterwards.

Source files
------------

// File: rtl/fp_add_sub.sv
// Seven-stage IEEE-754 binary32 adder/subtractor; denormals read as zero, tiny results flush to zero.
// Every stage advances only on clk_en; specials bypass the datapath alongside it.
module fp_add_sub #(
  parameter int unsigned LATENCY = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        add_sub,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  if (LATENCY != 7) begin : g_latency_check
    $error("fp_add_sub: LATENCY is fixed at 7");
  end

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // stage 1: unpack / specials
  logic        c1_sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, c1_spec;
  logic [31:0] c1_sval;
  logic        s1_sa, s1_sb, s1_spec;
  logic [7:0]  s1_ea, s1_eb;
  logic [23:0] s1_ma, s1_mb;
  logic [31:0] s1_sval;
  // stage 2: compare / swap
  logic        c2_swap;
  logic        s2_sign, s2_sub, s2_zsign, s2_spec;
  logic [7:0]  s2_exp, s2_shift;
  logic [23:0] s2_ml, s2_ms;
  logic [31:0] s2_sval;
  // stage 3: align
  logic [4:0]  c3_shc;
  logic [26:0] c3_kept, c3_lost;
  logic        s3_sign, s3_sub, s3_zsign, s3_spec;
  logic [7:0]  s3_exp;
  logic [23:0] s3_ml;
  logic [26:0] s3_al;
  logic [31:0] s3_sval;
  // stage 4: add / subtract
  logic        s4_sign, s4_zsign, s4_spec;
  logic [7:0]  s4_exp;
  logic [27:0] s4_sum;
  logic [31:0] s4_sval;
  // stage 5: normalize
  logic [4:0]        c5_lz;
  logic [26:0]       c5_norm;
  logic signed [9:0] c5_exp;
  logic              s5_sign, s5_spec;
  logic [26:0]       s5_norm;
  logic signed [9:0] s5_exp;
  logic [31:0]       s5_sval;
  // stage 6: round
  logic        c6_up, c6_carry;
  logic [22:0] c6_frac;
  logic [9:0]  c6_exp;
  logic        s6_sign, s6_zero, s6_ovf, s6_spec;
  logic [7:0]  s6_exp;
  logic [22:0] s6_frac;
  logic [31:0] s6_sval;
  // stage 7: pack
  logic [31:0] c7_res;

  always_comb begin
    c1_sb   = datab[31] ^ ~add_sub;
    a_nan   = (&dataa[30:23]) & (|dataa[22:0]);
    b_nan   = (&datab[30:23]) & (|datab[22:0]);
    a_inf   = (&dataa[30:23]) & ~(|dataa[22:0]);
    b_inf   = (&datab[30:23]) & ~(|datab[22:0]);
    a_zero  = (dataa[30:23] == 8'd0);
    b_zero  = (datab[30:23] == 8'd0);
    c1_spec = 1'b1;
    c1_sval = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (dataa[31] != c1_sb))) c1_sval = QNAN;
    else if (a_inf) c1_sval = {dataa[31], 8'hFF, 23'd0};
    else if (b_inf) c1_sval = {c1_sb, 8'hFF, 23'd0};
    else            c1_spec = 1'b0;
  end

  always_comb begin
    c2_swap = {s1_eb, s1_mb} > {s1_ea, s1_ma};
  end

  // shifts of 27 or more leave the small operand only in the sticky bit
  always_comb begin
    c3_shc = (s2_shift > 8'd27) ? 5'd27 : s2_shift[4:0];
    {c3_kept, c3_lost} = {s2_ms, 3'b000, 27'd0} >> c3_shc;
  end

  always_comb begin
    c5_lz = 5'd27;
    for (int unsigned i = 0; i < 27; i++)
      if (s4_sum[i]) c5_lz = 5'(26 - i);
    if (s4_sum[27]) begin
      c5_norm = {s4_sum[27:2], |s4_sum[1:0]};
      c5_exp  = $signed({2'b00, s4_exp}) + 10'sd1;
    end else begin
      c5_norm = s4_sum[26:0] << c5_lz;
      c5_exp  = $signed({2'b00, s4_exp}) - $signed({5'd0, c5_lz});
    end
  end

  // a frac carry-out means the significand rounded up to 2.0 and frac is already zero
  always_comb begin
    c6_up = s5_norm[2] & (s5_norm[3] | (|s5_norm[1:0]));
    {c6_carry, c6_frac} = {1'b0, s5_norm[25:3]} + {23'd0, c6_up};
    c6_exp = s5_exp + {9'd0, c6_carry};
  end

  always_comb begin
    if (s6_spec)      c7_res = s6_sval;
    else if (s6_zero) c7_res = {s6_sign, 31'd0};
    else if (s6_ovf)  c7_res = {s6_sign, 8'hFF, 23'd0};
    else              c7_res = {s6_sign, s6_exp, s6_frac};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_sa <= 1'b0; s1_sb <= 1'b0; s1_spec <= 1'b0; s1_ea <= '0; s1_eb <= '0;
      s1_ma <= '0; s1_mb <= '0; s1_sval <= '0;
      s2_sign <= 1'b0; s2_sub <= 1'b0; s2_zsign <= 1'b0; s2_spec <= 1'b0;
      s2_exp <= '0; s2_shift <= '0; s2_ml <= '0; s2_ms <= '0; s2_sval <= '0;
      s3_sign <= 1'b0; s3_sub <= 1'b0; s3_zsign <= 1'b0; s3_spec <= 1'b0;
      s3_exp <= '0; s3_ml <= '0; s3_al <= '0; s3_sval <= '0;
      s4_sign <= 1'b0; s4_zsign <= 1'b0; s4_spec <= 1'b0; s4_exp <= '0;
      s4_sum <= '0; s4_sval <= '0;
      s5_sign <= 1'b0; s5_spec <= 1'b0; s5_norm <= '0; s5_exp <= '0; s5_sval <= '0;
      s6_sign <= 1'b0; s6_zero <= 1'b0; s6_ovf <= 1'b0; s6_spec <= 1'b0;
      s6_exp <= '0; s6_frac <= '0; s6_sval <= '0;
      result <= '0;
    end else if (clk_en) begin
      s1_sa   <= dataa[31];
      s1_sb   <= c1_sb;
      s1_ea   <= a_zero ? 8'd0 : dataa[30:23];
      s1_eb   <= b_zero ? 8'd0 : datab[30:23];
      s1_ma   <= a_zero ? 24'd0 : {1'b1, dataa[22:0]};
      s1_mb   <= b_zero ? 24'd0 : {1'b1, datab[22:0]};
      s1_spec <= c1_spec;
      s1_sval <= c1_sval;

      s2_sign  <= c2_swap ? s1_sb : s1_sa;
      s2_exp   <= c2_swap ? s1_eb : s1_ea;
      s2_ml    <= c2_swap ? s1_mb : s1_ma;
      s2_ms    <= c2_swap ? s1_ma : s1_mb;
      s2_shift <= c2_swap ? (s1_eb - s1_ea) : (s1_ea - s1_eb);
      s2_sub   <= s1_sa ^ s1_sb;
      s2_zsign <= s1_sa & s1_sb;
      s2_spec  <= s1_spec;
      s2_sval  <= s1_sval;

      s3_sign  <= s2_sign;
      s3_sub   <= s2_sub;
      s3_zsign <= s2_zsign;
      s3_exp   <= s2_exp;
      s3_ml    <= s2_ml;
      s3_al    <= {c3_kept[26:1], c3_kept[0] | (|c3_lost)};
      s3_spec  <= s2_spec;
      s3_sval  <= s2_sval;

      s4_sign  <= s3_sign;
      s4_zsign <= s3_zsign;
      s4_exp   <= s3_exp;
      s4_sum   <= s3_sub ? ({1'b0, s3_ml, 3'b000} - {1'b0, s3_al})
                         : ({1'b0, s3_ml, 3'b000} + {1'b0, s3_al});
      s4_spec  <= s3_spec;
      s4_sval  <= s3_sval;

      // a zero sum takes +0 unless both addends were negative zeros
      s5_sign <= (s4_sum == 28'd0) ? s4_zsign : s4_sign;
      s5_norm <= c5_norm;
      s5_exp  <= c5_exp;
      s5_spec <= s4_spec;
      s5_sval <= s4_sval;

      s6_sign <= s5_sign;
      s6_zero <= ~s5_norm[26] | (s5_exp <= 10'sd0);
      s6_ovf  <= (c6_exp >= 10'd255);
      s6_exp  <= c6_exp[7:0];
      s6_frac <= c6_frac;
      s6_spec <= s5_spec;
      s6_sval <= s5_sval;

      result <= c7_res;
    end
  end

endmodule

// File: tb/tb_fp_add_sub.sv
// Directed-vector bench for fp_add_sub: single issue, back-to-back stream, stall and mid-flight reset.
module tb_fp_add_sub;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        add_sub;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] want;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fp_add_sub #(.LATENCY(7)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .clk_en (clk_en),
    .add_sub(add_sub),
    .dataa  (dataa),
    .datab  (datab),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: result=%h expected=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op);
    dataa   = a;
    datab   = b;
    add_sub = op;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b1);
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] want, input string name);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.want = want; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0;
    clk_en  = 1'b0;
    idle();

    add_vec(32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, "one_plus_two");
    add_vec(32'h3FC00000, 32'h3F000000, 1'b0, 32'h3F800000, "sub_1p5_0p5");
    add_vec(32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, "cancel");
    add_vec(32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, "tie_even");
    add_vec(32'h3F800000, 32'h33C00000, 1'b1, 32'h3F800001, "above_half");
    add_vec(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, "overflow");
    add_vec(32'h7F800000, 32'hFF800000, 1'b1, 32'h7FC00000, "inf_minus_inf");
    add_vec(32'h00000001, 32'h00000000, 1'b1, 32'h00000000, "denorm_zero");
    add_vec(32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, "carry_out");
    add_vec(32'h40000000, 32'h40400000, 1'b0, 32'hBF800000, "neg_result");
    add_vec(32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, "nan_a");
    add_vec(32'h3F800000, 32'hFFC00000, 1'b0, 32'h7FC00000, "nan_b");
    add_vec(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, "inf_minus_fin");
    add_vec(32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, "ninf_plus_fin");
    add_vec(32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, "inf_sub_inf");
    add_vec(32'h80000000, 32'h80000000, 1'b1, 32'h80000000, "negz_plus_negz");
    add_vec(32'h80000000, 32'h00000000, 1'b0, 32'h80000000, "negz_sub_posz");
    add_vec(32'h00000000, 32'h80000000, 1'b1, 32'h00000000, "posz_plus_negz");
    add_vec(32'h80000001, 32'h80000000, 1'b1, 32'h80000000, "neg_denorm");
    add_vec(32'h3F800000, 32'h0C000000, 1'b1, 32'h3F800000, "far_add");
    add_vec(32'h3F800000, 32'h0C000000, 1'b0, 32'h3F800000, "far_sub");
    add_vec(32'h00800000, 32'h00800001, 1'b0, 32'h80000000, "underflow");

    #12;
    check("reset_low", result, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    check("after_reset", result, 32'h0);
    clk_en = 1'b1;

    // single issue: nothing visible after 6 edges, result after the 7th
    foreach (vecs[k]) begin
      drive(vecs[k].a, vecs[k].b, vecs[k].op);
      step();
      idle();
      repeat (5) step();
      check({vecs[k].name, "_edge6"}, result, 32'h0);
      step();
      check(vecs[k].name, result, vecs[k].want);
    end

    // back-to-back stream, results in issue order
    for (int c = 0; c < vecs.size() + 6; c++) begin
      if (c < vecs.size()) drive(vecs[c].a, vecs[c].b, vecs[c].op);
      else idle();
      step();
      if (c >= 6) check({"stream_", vecs[c - 6].name}, result, vecs[c - 6].want);
    end

    // stall mid-flight with the second operation still in the pipe
    idle();
    repeat (7) step();
    drive(32'h3F800000, 32'h40000000, 1'b1);
    step();
    drive(32'h3FC00000, 32'h3F000000, 1'b0);
    step();
    idle();
    repeat (4) step();
    check("stall_pre_edge6", result, 32'h0);
    step();
    check("stall_first", result, 32'h40400000);
    clk_en = 1'b0;
    drive(32'h3F800000, 32'h3F800000, 1'b1);
    repeat (3) begin
      step();
      check("stall_hold", result, 32'h40400000);
    end
    idle();
    clk_en = 1'b1;
    step();
    check("stall_second", result, 32'h3F800000);
    repeat (6) begin
      step();
      check("stall_no_extra", result, 32'h0);
    end

    // reset with two operations in flight
    drive(32'h3F800000, 32'h40000000, 1'b1);
    step();
    drive(32'h3FC00000, 32'h3F000000, 1'b0);
    step();
    drive(32'h3F800000, 32'h33C00000, 1'b1);
    step();
    idle();
    repeat (4) step();
    check("rst_first", result, 32'h40400000);
    #2 reset_n = 1'b0;
    #1 check("rst_async_clear", result, 32'h0);
    step();
    check("rst_held", result, 32'h0);
    reset_n = 1'b1;
    repeat (8) begin
      step();
      check("rst_no_stale", result, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
